// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates ICache fetches and LSB loads/stores onto the byte-wide RAM/IO bus.
// Optional MEM_CTRL_IO_STALL_EN holds IO-space writes (addr[17:16] == 2'b11) while the UART buffer is full.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_addr_enable,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        lsb_enable,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        owner_r;
    logic [31:0] base_r, wdata_r, buf_r, buf_nxt_s, addr_s;
    logic [2:0]  len_r, cnt_r, rcv_r;
    logic [31:0] if_inst_r, lsb_rdata_r;
    logic        issue_s, capture_s, last_rd_s, last_wr_s, io_stall_s;
    logic [31:0] mem_a_s;
    logic [7:0]  mem_dout_s;
    logic        mem_wr_s, if_valid_s, lsb_valid_s;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall_s = (state_r == WRITE) && (addr_s[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_full_s;
    assign unused_io_full_s = io_buffer_full;
    assign io_stall_s       = 1'b0;
`endif

    assign addr_s    = base_r + {29'd0, cnt_r};
    assign issue_s   = ((state_r == READ) || (state_r == WRITE)) && (cnt_r < len_r) && !io_stall_s;
    assign capture_s = (state_r == READ) && (cnt_r != 3'd0);
    assign last_rd_s = capture_s && ((rcv_r + 3'd1) == len_r);
    assign last_wr_s = (state_r == WRITE) && issue_s && ((cnt_r + 3'd1) == len_r);

    // Buffer with the byte arriving this cycle merged in (little-endian slot rcv).
    always_comb begin
        buf_nxt_s = buf_r;
        buf_nxt_s[{rcv_r[1:0], 3'b000} +: 8] = mem_din;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (rdy) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the LSB wins arbitration in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (lsb_enable) begin
                    if (lsb_wr) state_nxt_s = WRITE;
                    else        state_nxt_s = READ;
                end else if (if_addr_enable) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (last_rd_s) state_nxt_s = DONE;
                else           state_nxt_s = READ;
            end
            WRITE: begin
                if (last_wr_s) state_nxt_s = DONE;
                else           state_nxt_s = WRITE;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bus and completion outputs. While stalled in READ the pending byte's
    // address is re-presented so mem_din carries it again when rdy returns.
    always_comb begin
        mem_a_s     = 32'd0;
        mem_dout_s  = 8'd0;
        mem_wr_s    = 1'b0;
        if_valid_s  = 1'b0;
        lsb_valid_s = 1'b0;
        case (state_r)
            READ: begin
                if (!rdy)         mem_a_s = base_r + {29'd0, rcv_r};
                else if (issue_s) mem_a_s = addr_s;
                else              mem_a_s = 32'd0;
            end
            WRITE: begin
                if (issue_s) begin
                    mem_a_s    = addr_s;
                    mem_dout_s = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
                    mem_wr_s   = rdy;
                end else begin
                    mem_a_s    = 32'd0;
                    mem_dout_s = 8'd0;
                    mem_wr_s   = 1'b0;
                end
            end
            DONE: begin
                if_valid_s  = rdy && !owner_r;
                lsb_valid_s = rdy && owner_r;
            end
            default: begin
                mem_a_s = 32'd0;
            end
        endcase
    end

    // Request latch, byte counters, assembly buffer and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= 1'b0;
            base_r      <= 32'd0;
            wdata_r     <= 32'd0;
            len_r       <= 3'd0;
            cnt_r       <= 3'd0;
            rcv_r       <= 3'd0;
            buf_r       <= 32'd0;
            if_inst_r   <= 32'd0;
            lsb_rdata_r <= 32'd0;
        end else if (rdy) begin
            case (state_r)
                IDLE: begin
                    if (lsb_enable) begin
                        owner_r <= 1'b1;
                        base_r  <= lsb_addr;
                        wdata_r <= lsb_wdata;
                        len_r   <= size_to_len(lsb_size);
                    end else if (if_addr_enable) begin
                        owner_r <= 1'b0;
                        base_r  <= if_addr;
                        len_r   <= 3'd4;
                    end
                    cnt_r <= 3'd0;
                    rcv_r <= 3'd0;
                    buf_r <= 32'd0;
                end
                READ: begin
                    if (issue_s) cnt_r <= cnt_r + 3'd1;
                    if (capture_s) begin
                        buf_r <= buf_nxt_s;
                        rcv_r <= rcv_r + 3'd1;
                    end
                    // Result registers load on the edge into DONE so they are valid with the pulse.
                    if (last_rd_s) begin
                        if (owner_r) lsb_rdata_r <= buf_nxt_s;
                        else         if_inst_r   <= buf_nxt_s;
                    end
                end
                WRITE: begin
                    if (issue_s) cnt_r <= cnt_r + 3'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign mem_a     = mem_a_s;
    assign mem_dout  = mem_dout_s;
    assign mem_wr    = mem_wr_s;
    assign if_valid  = if_valid_s;
    assign lsb_valid = lsb_valid_s;
    assign if_inst   = if_inst_r;
    assign lsb_rdata = lsb_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven directed vectors plus hand-written multi-cycle sequences for mem_ctrl.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full;
    logic        if_addr_enable, lsb_enable, lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] if_addr, lsb_addr, lsb_wdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a, if_inst, lsb_rdata;
    logic        mem_wr, if_valid, lsb_valid;

    logic [7:0]  ram [0:65535];
    logic [31:0] wr_addr [0:63];
    logic [7:0]  wr_data [0:63];
    int          wr_n = 0;
    int          n_checks = 0;
    int          n_err = 0;

    typedef struct {
        logic        is_lsb;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_nwr;
    } vec_t;

    vec_t vecs [0:9];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_addr_enable(if_addr_enable), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
        .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read data one cycle after the address; writes go to a log.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) begin
            wr_addr[6'(wr_n)] <= mem_a;
            wr_data[6'(wr_n)] <= mem_dout;
            wr_n              <= wr_n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input logic is_lsb, input int n0, output int lat);
        int n;
        logic got;
        n   = n0;
        got = 1'b0;
        lat = -1;
        while (!got && (n < n0 + 40)) begin
            @(posedge clk); #1;
            n++;
            if ((is_lsb && lsb_valid) || (!is_lsb && if_valid)) begin
                got = 1'b1;
                lat = n;
            end
        end
    endtask

    task automatic check_writes(input string name, input int w0, input int nexp,
                                input logic [31:0] addr, input logic [31:0] wdata);
        chk($sformatf("%s write count", name), 32'(wr_n - w0), 32'(nexp));
        for (int j = 0; j < nexp; j++) begin
            chk($sformatf("%s write%0d addr", name, j), wr_addr[6'(w0 + j)], addr + 32'(j));
            chk($sformatf("%s write%0d data", name, j), {24'd0, wr_data[6'(w0 + j)]},
                (wdata >> (8 * j)) & 32'h0000_00FF);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, w0;
        w0 = wr_n;
        if (v.is_lsb) begin
            lsb_enable = 1'b1; lsb_wr = v.wr; lsb_addr = v.addr;
            lsb_size = v.size; lsb_wdata = v.wdata;
        end else begin
            if_addr_enable = 1'b1; if_addr = v.addr;
        end
        wait_valid(v.is_lsb, 0, lat);
        chk($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("vec%0d data", idx), v.is_lsb ? lsb_rdata : if_inst, v.exp_data);
        lsb_enable = 1'b0;
        if_addr_enable = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("vec%0d single pulse", idx), 32'(v.is_lsb ? lsb_valid : if_valid), 32'd0);
        check_writes($sformatf("vec%0d", idx), w0, v.exp_nwr, v.addr, v.wdata);
    endtask

    initial begin
        int lat, w0;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        if_addr_enable = 1'b0; if_addr = 32'd0;
        lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_size = 2'd0; lsb_wdata = 32'd0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22; ram[16'h0202] = 8'h33;
        ram[16'h0203] = 8'h44; ram[16'h0204] = 8'h55;
        ram[16'hFFFF] = 8'hA5; ram[16'h0000] = 8'h3C;

        //          lsb   wr    addr           size  wdata          exp_data       lat nwr
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd0, 32'h0000_0000, 32'h0000_0513, 6, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0201, 2'd0, 32'h0000_0000, 32'h0000_0022, 3, 0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 2'd1, 32'h0000_0000, 32'h0000_5544, 4, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 2'd2, 32'h0000_0000, 32'h4433_2211, 6, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0201, 2'd3, 32'h0000_0000, 32'h5544_3322, 6, 0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_2001, 2'd1, 32'hDEAD_BEEF, 32'h5544_3322, 3, 2};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_4000, 2'd2, 32'h1234_5678, 32'h5544_3322, 5, 4};
        vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_ABCD, 32'h5544_3322, 3, 2};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 32'h0000_3CA5, 4, 0};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_0200, 2'd0, 32'h0000_0000, 32'h4433_2211, 6, 0};

        #2 rst = 1'b0;
        #1;
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset lsb_valid", 32'(lsb_valid), 32'd0);
        chk("reset if_inst", if_inst, 32'd0);
        chk("reset lsb_rdata", lsb_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Simultaneous requests: LSB byte load first, IF accepted after the LSB's DONE.
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h0000_0202; lsb_size = 2'd0;
        if_addr_enable = 1'b1; if_addr = 32'h0000_0100;
        wait_valid(1'b1, 0, lat);
        chk("simul lsb latency", 32'(lat), 32'd3);
        chk("simul lsb data", lsb_rdata, 32'h0000_0033);
        chk("simul no if_valid with lsb", 32'(if_valid), 32'd0);
        lsb_enable = 1'b0;
        wait_valid(1'b0, lat, lat);
        chk("simul if latency", 32'(lat), 32'd10);
        chk("simul if data", if_inst, 32'h0000_0513);
        if_addr_enable = 1'b0;
        @(posedge clk); #1;

        // rdy low for 3 cycles after the first byte of a word load.
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h0000_0200; lsb_size = 2'd2;
        repeat (3) begin @(posedge clk); #1; end
        rdy = 1'b0;
        repeat (3) begin
            chk("stall no lsb_valid", 32'(lsb_valid), 32'd0);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        wait_valid(1'b1, 6, lat);
        chk("stall read latency", 32'(lat), 32'd9);
        chk("stall read data", lsb_rdata, 32'h4433_2211);
        lsb_enable = 1'b0;
        @(posedge clk); #1;

        // rdy low while in DONE: pulse deferred until rdy returns.
        if_addr_enable = 1'b1; if_addr = 32'h0000_0100;
        repeat (6) begin @(posedge clk); #1; end
        chk("done pulse at t+6", 32'(if_valid), 32'd1);
        rdy = 1'b0;
        #1 chk("done pulse masked by rdy", 32'(if_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("done pulse still masked", 32'(if_valid), 32'd0);
        rdy = 1'b1;
        #1 chk("done pulse after rdy", 32'(if_valid), 32'd1);
        chk("done pulse data", if_inst, 32'h0000_0513);
        if_addr_enable = 1'b0;
        @(posedge clk); #1;
        chk("done pulse one cycle", 32'(if_valid), 32'd0);

        // Async reset at t+2 of a word store: only byte 0 lands.
        w0 = wr_n;
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0000_5000; lsb_size = 2'd2;
        lsb_wdata = 32'hCAFE_F00D;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        lsb_enable = 1'b0;
        #1;
        chk("midrst mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst mem_a", mem_a, 32'd0);
        chk("midrst mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("midrst lsb_rdata", lsb_rdata, 32'd0);
        chk("midrst if_inst", if_inst, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_writes("midrst", w0, 1, 32'h0000_5000, 32'h0000_000D);
        run_vec(vecs[9], 10);

        // IO-space byte store with the UART buffer full for 4 cycles.
        w0 = wr_n;
        io_buffer_full = 1'b1;
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_size = 2'd0;
        lsb_wdata = 32'h0000_0077;
`ifdef MEM_CTRL_IO_STALL_EN
        repeat (5) begin @(posedge clk); #1; end
        chk("io stall no write", 32'(wr_n - w0), 32'd0);
        io_buffer_full = 1'b0;
        wait_valid(1'b1, 5, lat);
        chk("io stall latency", 32'(lat), 32'd6);
`else
        wait_valid(1'b1, 0, lat);
        chk("io ignored latency", 32'(lat), 32'd2);
        io_buffer_full = 1'b0;
`endif
        lsb_enable = 1'b0;
        @(posedge clk); #1;
        check_writes("io", w0, 1, 32'h0003_0000, 32'h0000_0077);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
